// File: rtl/baud_tick_gen_16x.sv
// rtl/baud_tick_gen_16x.sv - programmable UART baud tick generator (16x and 1x strobes)
module baud_tick_gen_16x #(
  parameter int CNT_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] baud_div,
  output logic             baud_tick_16x,
  output logic             baud_tick_1x,
  output logic [CNT_W-1:0] count,
  output logic             count_clr
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  logic [SUB_W-1:0] sub_cnt;
  logic [CNT_W-1:0] div_m1;
  logic             term;

  // A divisor of 0 behaves as 1, so its terminal count is 0 as well.
  always_comb begin
    div_m1 = '0;
    if (baud_div != '0) begin
      div_m1 = baud_div - CNT_W'(1);
    end
  end

  // >= rather than == so a shrinking divisor wraps on the next edge.
  assign term          = (count >= div_m1) && !rst_n;
  assign baud_tick_16x = term;
  assign count_clr     = term;
  assign baud_tick_1x  = term && (sub_cnt == SUB_LAST);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count <= '0;
    end else if (term) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Power-of-two OVERSAMPLE lets the sub-counter wrap naturally.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sub_cnt <= '0;
    end else if (term) begin
      sub_cnt <= sub_cnt + SUB_W'(1);
    end
  end

endmodule

// File: tb/tb_baud_tick_gen_16x.sv
// tb/tb_baud_tick_gen_16x.sv - scoreboard bench for baud_tick_gen_16x
module tb_baud_tick_gen_16x;

  typedef struct packed {
    logic [15:0] cnt;
    logic        t16;
    logic        t1x;
    logic        clr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        baud_tick_16x;
  logic        baud_tick_1x;
  logic [15:0] count;
  logic        count_clr;

  exp_t        exp_q[$];
  int          compared;
  int          mismatched;
  int          n16;
  int          n1x;
  int          cyc;
  int          first1x;
  logic [15:0] m_count;
  logic [3:0]  m_sub;

  baud_tick_gen_16x #(.CNT_W(16), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_div     (baud_div),
    .baud_tick_16x(baud_tick_16x),
    .baud_tick_1x (baud_tick_1x),
    .count        (count),
    .count_clr    (count_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per clock, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc     = 0;
        first1x = 0;
      end else begin
        cyc = cyc + 1;
        if (baud_tick_1x === 1'b1 && first1x == 0) first1x = cyc;
      end
      if (baud_tick_16x === 1'b1) n16 = n16 + 1;
      if (baud_tick_1x === 1'b1) n1x = n1x + 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared = compared + 1;
        if ({count, baud_tick_16x, baud_tick_1x, count_clr} !== e) begin
          mismatched = mismatched + 1;
          $display("FAIL cycle_out t=%0t actual count=%0d t16=%b t1x=%b clr=%b expected count=%0d t16=%b t1x=%b clr=%b",
                   $time, count, baud_tick_16x, baud_tick_1x, count_clr, e.cnt, e.t16, e.t1x, e.clr);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    compared = compared + 1;
    if (act != exp_v) begin
      mismatched = mismatched + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Drive one cycle and queue the expected outputs for it.
  task automatic step(input logic r, input logic [15:0] d);
    logic [15:0] de;
    logic        term;
    exp_t        e;
    rst_n    = r;
    baud_div = d;
    de       = (d == 16'd0) ? 16'd1 : d;
    term     = !r && (m_count >= de - 16'd1);
    e.cnt    = m_count;
    e.t16    = term;
    e.t1x    = term && (m_sub == 4'd15);
    e.clr    = term;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_count = 16'd0;
      m_sub   = 4'd0;
    end else if (term) begin
      m_count = 16'd0;
      m_sub   = m_sub + 4'd1;
    end else begin
      m_count = m_count + 16'd1;
    end
    #1;
  endtask

  initial begin
    int a16;
    int a1x;
    compared   = 0;
    mismatched = 0;
    n16        = 0;
    n1x        = 0;
    cyc        = 0;
    first1x    = 0;
    m_count    = 16'd0;
    m_sub      = 4'd0;
    rst_n      = 1'b1;
    baud_div   = 16'd5;
    @(posedge clk);
    #1;

    // Reset hold
    for (int i = 0; i < 3; i++) step(1'b1, 16'd5);

    // Nominal divisor 5 for 500 cycles
    a16 = n16; a1x = n1x;
    for (int i = 0; i < 500; i++) step(1'b0, 16'd5);
    check("nominal_16x_pulses", n16 - a16, 100);
    check("nominal_1x_pulses", n1x - a1x, 6);

    // Divisor 1 and 0
    step(1'b1, 16'd1);
    a16 = n16; a1x = n1x;
    for (int i = 0; i < 32; i++) step(1'b0, 16'd1);
    check("div1_16x_pulses", n16 - a16, 32);
    check("div1_1x_pulses", n1x - a1x, 2);
    check("div1_first_1x", first1x, 16);

    step(1'b1, 16'd0);
    a16 = n16; a1x = n1x;
    for (int i = 0; i < 32; i++) step(1'b0, 16'd0);
    check("div0_16x_pulses", n16 - a16, 32);
    check("div0_1x_pulses", n1x - a1x, 2);
    check("div0_first_1x", first1x, 16);

    // Decrease 100 -> 10 at count 50
    step(1'b1, 16'd100);
    a16 = n16;
    for (int i = 0; i < 50; i++) step(1'b0, 16'd100);
    check("dec_no_tick_before", n16 - a16, 0);
    step(1'b0, 16'd10);
    check("dec_tick_immediate", n16 - a16, 1);
    for (int i = 0; i < 30; i++) step(1'b0, 16'd10);
    check("dec_10clk_period", n16 - a16, 4);

    // Increase 5 -> 8 at count 3
    step(1'b1, 16'd5);
    a16 = n16;
    for (int i = 0; i < 3; i++) step(1'b0, 16'd5);
    for (int i = 0; i < 4; i++) step(1'b0, 16'd8);
    check("inc_no_tick_at_4", n16 - a16, 0);
    step(1'b0, 16'd8);
    check("inc_tick_at_7", n16 - a16, 1);
    for (int i = 0; i < 16; i++) step(1'b0, 16'd8);
    check("inc_8clk_period", n16 - a16, 3);

    // Mid-run reset at count 2 after seven 16x ticks
    step(1'b1, 16'd5);
    a16 = n16;
    for (int i = 0; i < 37; i++) step(1'b0, 16'd5);
    check("midrst_ticks_before", n16 - a16, 7);
    step(1'b1, 16'd5);
    a1x = n1x;
    for (int i = 0; i < 80; i++) step(1'b0, 16'd5);
    check("midrst_first_1x", first1x, 80);
    check("midrst_1x_pulses", n1x - a1x, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen_16x.md
Name: baud_tick_gen_16x

Overview:
- Programmable UART baud-rate tick generator. Divides the system clock by a runtime divisor to produce a 16x oversampling strobe and a 1x bit-rate strobe.
- Integrates the free-running cycle counter and the divide/oversample logic in one block.
- Feeds the UART RX sampler (16x tick) and the TX shifter (1x tick).

Parameters:
- CNT_W, 16, width of the divisor input and of the cycle counter.
- OVERSAMPLE, 16, number of 16x ticks per 1x tick; must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
- baud_div  input  CNT_W  clocks per 16x tick; sampled every cycle, no latching.
- baud_tick_16x  output  1  one-clock strobe at the 16x oversample rate.
- baud_tick_1x  output  1  one-clock strobe at the bit rate.
- count  output  CNT_W  current cycle-counter value, for debug and observability.
- count_clr  output  1  high in the cycle where the counter wraps to 0 on the next edge.

Behaviour:
- Reset (rst_n=1 at an edge): count=0, oversample sub-counter=0. While reset is held, baud_tick_16x=0, baud_tick_1x=0 and count_clr=0, regardless of count.
- Effective divisor: div_eff = max(baud_div, 1). A divisor of 0 behaves as 1.
- Terminal condition: term = (count >= div_eff-1) and not rst_n. The >= compare ensures that a mid-run decrease of baud_div wraps on the next edge rather than running to 2^CNT_W.
- baud_tick_16x = term and count_clr = term. Both are combinational decodes of registered state, so each is a single-cycle pulse.
- Counter update per edge:
  - reset → 0
  - else if term → 0
  - else → count+1
- Period: baud_tick_16x pulses every div_eff clocks. For div_eff=1 it is high every non-reset cycle.
- Sub-counter (width log2(OVERSAMPLE)):
  - Increments by 1 on each edge where baud_tick_16x=1.
  - Wraps from OVERSAMPLE-1 to 0.
  - Cleared by reset.
- baud_tick_1x = baud_tick_16x and (sub-counter == OVERSAMPLE-1).
  - Pulses every OVERSAMPLE*div_eff clocks, coincident with a 16x tick.
- First ticks after reset release:
  - First 16x tick occurs in the div_eff-th cycle after release, counting the first cycle with count=0 as cycle 1.
  - First 1x tick occurs in cycle OVERSAMPLE*div_eff.
- Change of baud_div mid-run: takes effect immediately through the compare. Neither the sub-counter nor the 1x phase is reset.
- Reset mid-operation: all state returns to 0 at that edge, and ticks are suppressed for that cycle.
- No overflow possible: count never exceeds 2^CNT_W-2 because the compare always fires at div_eff-1.

Test Plan:
- Reset hold: rst_n=1 for 3 cycles with baud_div=5 → count=0, baud_tick_16x=0, baud_tick_1x=0, count_clr=0 throughout.
- Nominal: baud_div=5, release reset, run 500 cycles →
  - count sequence is 0,1,2,3,4,0,…
  - baud_tick_16x high only when count=4, every 5 clocks: 100 pulses.
  - count_clr is identical to baud_tick_16x.
  - baud_tick_1x high every 80 clocks (first in cycle 80): 6 pulses in 500 cycles.
- Divisor edge cases:
  - baud_div=1 → baud_tick_16x high every cycle, count stays 0, baud_tick_1x every 16 cycles.
  - baud_div=0 → identical to baud_div=1.
- Divisor decrease on the fly: run baud_div=100 until count=50, then set baud_div=10 → next edge count=0 (the tick fires in that cycle), then a 10-clock period.
- Divisor increase on the fly: at count=3 with baud_div=5, set baud_div=8 → count continues to 7, tick at count=7, then an 8-clock period.
- Mid-run reset: assert rst_n for 1 cycle at count=2 after 7 16x ticks → count=0 and sub-counter=0; the next baud_tick_1x comes 16*div_eff clocks after release.
